// File: rtl/our_packet_dispatch_pkg.sv
// Shared constants and state encoding for the packet dispatcher, TWO parser and TX framer.
// Header byte positions are fixed by the frame layout: DA 0-5, SA 6-11, EtherType 12-13, type 14.
package our_packet_dispatch_pkg;

  localparam logic [15:0] OPD_ETHERTYPE = 16'h88B5;
  localparam logic [7:0]  OPD_TYPE_ONE  = 8'h01;
  localparam logic [7:0]  OPD_TYPE_TWO  = 8'h02;
  localparam logic [47:0] OPD_BCAST_MAC = 48'hFFFF_FFFF_FFFF;
  localparam int          OPD_ONE_LEN   = 524;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    HDR      = 3'd1,
    PASS_ONE = 3'd2,
    PASS_TWO = 3'd3,
    DROP     = 3'd4
  } dispatch_state_t;

  // MAC addresses go on the wire MSB byte first.
  function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [2:0] i);
    case (i)
      3'd0:    mac_byte = mac[47:40];
      3'd1:    mac_byte = mac[39:32];
      3'd2:    mac_byte = mac[31:24];
      3'd3:    mac_byte = mac[23:16];
      3'd4:    mac_byte = mac[15:8];
      3'd5:    mac_byte = mac[7:0];
      default: mac_byte = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/our_packet_dispatch_if.sv
// Receive byte stream into the dispatcher and the shared payload stream out of it.
interface our_packet_dispatch_if;
  logic [7:0] rx_data;
  logic       rx_dv;
  logic [7:0] data_out;
  logic       ena_one;
  logic       ena_two;

  modport master (output rx_data, rx_dv, input data_out, ena_one, ena_two);
  modport slave  (input rx_data, rx_dv, output data_out, ena_one, ena_two);
endinterface

// File: rtl/our_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module our_sat_counter #(
  parameter int DATA_W = 16
) (
  input  logic              clock,
  input  logic              aclr,
  input  logic              inc,
  output logic [DATA_W-1:0] count
);

  logic [DATA_W-1:0] count_q;

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      count_q <= '0;
    end else if (inc && (count_q != {DATA_W{1'b1}})) begin
      count_q <= count_q + DATA_W'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/our_packet_dispatch.sv
// Parses the 16-byte Ethernet/type header on the fly and steers the payload to the
// ONE or TWO consumer with one cycle of latency; everything else is counted and dropped.
module our_packet_dispatch
  import our_packet_dispatch_pkg::*;
#(
  parameter logic [47:0] LOCAL_MAC = 48'h02_00_00_00_00_01,
  parameter logic [15:0] ETHERTYPE = OPD_ETHERTYPE,
  parameter logic [7:0]  TYPE_ONE  = OPD_TYPE_ONE,
  parameter logic [7:0]  TYPE_TWO  = OPD_TYPE_TWO,
  parameter int          ONE_LEN   = OPD_ONE_LEN
) (
  input  logic                 clock,
  input  logic                 aclr,
  our_packet_dispatch_if.slave pkt,
  output logic [47:0]          src_mac,
  output logic                 short_err,
  output logic [15:0]          cnt_one,
  output logic [15:0]          cnt_drop
);

  localparam logic [9:0] ONE_LEN_W = 10'(ONE_LEN);
  localparam logic [9:0] PAY_MAX   = 10'd1023;

  dispatch_state_t state, state_d;

  logic [4:0]  idx;
  logic [4:0]  byte_idx;
  logic        hdr_first;
  logic        hdr_byte;
  logic        dst_local_ok;
  logic        dst_bcast_ok;
  logic        etype_ok;
  logic [7:0]  type_q;
  logic [47:0] src_shift;
  logic        armed;
  logic [9:0]  pay_cnt;

  logic ena_one_p0;
  logic ena_two_p0;
  logic short_p0;
  logic hdr_done;
  logic take_src;
  logic inc_one;
  logic inc_drop;

  assign hdr_first = (state == IDLE);
  assign hdr_byte  = pkt.rx_dv && ((hdr_first && armed) || (state == HDR));
  assign byte_idx  = hdr_first ? 5'd0 : idx;

  // Header capture: byte 0 arrives while still in IDLE, so compares start there.
  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      idx          <= '0;
      dst_local_ok <= 1'b0;
      dst_bcast_ok <= 1'b0;
      etype_ok     <= 1'b0;
      type_q       <= '0;
      src_shift    <= '0;
    end else if (hdr_byte) begin
      idx <= byte_idx + 5'd1;
      if (byte_idx < 5'd6) begin
        dst_local_ok <= (hdr_first | dst_local_ok) &
                        (pkt.rx_data == mac_byte(LOCAL_MAC, byte_idx[2:0]));
        dst_bcast_ok <= (hdr_first | dst_bcast_ok) &
                        (pkt.rx_data == mac_byte(OPD_BCAST_MAC, byte_idx[2:0]));
      end
      if ((byte_idx >= 5'd6) && (byte_idx < 5'd12)) begin
        src_shift <= {src_shift[39:0], pkt.rx_data};
      end
      if (byte_idx == 5'd12) begin
        etype_ok <= (pkt.rx_data == ETHERTYPE[15:8]);
      end
      if (byte_idx == 5'd13) begin
        etype_ok <= etype_ok & (pkt.rx_data == ETHERTYPE[7:0]);
      end
      if (byte_idx == 5'd14) begin
        type_q <= pkt.rx_data;
      end
    end
  end

  // A frame already in flight at reset release must not be mistaken for a new one.
  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      armed   <= 1'b0;
      pay_cnt <= '0;
    end else begin
      if (!pkt.rx_dv) begin
        armed <= 1'b1;
      end
      if (state == HDR) begin
        pay_cnt <= '0;
      end else if ((state == PASS_ONE) && pkt.rx_dv && (pay_cnt != PAY_MAX)) begin
        pay_cnt <= pay_cnt + 10'd1;
      end
    end
  end

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE: begin
        if (pkt.rx_dv && armed) state_d = HDR;
      end
      HDR: begin
        if (!pkt.rx_dv) begin
          state_d = IDLE;
        end else if (idx == 5'd15) begin
          if ((dst_local_ok || dst_bcast_ok) && etype_ok && (type_q == TYPE_ONE)) begin
            state_d = PASS_ONE;
          end else if ((dst_local_ok || dst_bcast_ok) && etype_ok && (type_q == TYPE_TWO)) begin
            state_d = PASS_TWO;
          end else begin
            state_d = DROP;
          end
        end
      end
      PASS_ONE, PASS_TWO, DROP: begin
        if (!pkt.rx_dv) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ena_one_p0 = (state == PASS_ONE) && pkt.rx_dv;
    ena_two_p0 = (state == PASS_TWO) && pkt.rx_dv;
    short_p0   = (state == PASS_ONE) && !pkt.rx_dv && (pay_cnt < ONE_LEN_W);
    hdr_done   = (state == HDR) && pkt.rx_dv && (idx == 5'd15);
    take_src   = hdr_done && ((state_d == PASS_ONE) || (state_d == PASS_TWO));
    inc_one    = hdr_done && (state_d == PASS_ONE);
    inc_drop   = (state == HDR) && ((state_d == DROP) || (state_d == IDLE));
  end

  // Output register stage: payload and enables lag rx by exactly one cycle.
  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      pkt.data_out <= '0;
      pkt.ena_one  <= 1'b0;
      pkt.ena_two  <= 1'b0;
      src_mac      <= '0;
      short_err    <= 1'b0;
    end else begin
      pkt.ena_one <= ena_one_p0;
      pkt.ena_two <= ena_two_p0;
      short_err   <= short_p0;
      if (ena_one_p0 || ena_two_p0) begin
        pkt.data_out <= pkt.rx_data;
      end
      if (take_src) begin
        src_mac <= src_shift;
      end
    end
  end

  our_sat_counter #(.DATA_W(16)) u_cnt_one (
    .clock (clock),
    .aclr  (aclr),
    .inc   (inc_one),
    .count (cnt_one)
  );

  our_sat_counter #(.DATA_W(16)) u_cnt_drop (
    .clock (clock),
    .aclr  (aclr),
    .inc   (inc_drop),
    .count (cnt_drop)
  );

endmodule

// File: tb/tb_our_packet_dispatch.sv
// Directed bench for our_packet_dispatch: a frame table plus hand-written abort,
// back-to-back, mid-frame reset and counter-saturation sequences.
module tb_our_packet_dispatch;

  localparam logic [47:0] LMAC  = 48'h02_00_00_00_00_01;
  localparam logic [47:0] BMAC  = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] WMAC  = 48'h02_00_00_00_00_09;
  localparam logic [47:0] SA    = 48'h0A_11_22_33_44_55;
  localparam logic [47:0] SB    = 48'h0A_66_77_88_99_AA;
  localparam logic [47:0] SC    = 48'h0A_DE_AD_BE_EF_01;

  logic        clock = 1'b0;
  logic        aclr  = 1'b1;
  logic [47:0] src_mac;
  logic        short_err;
  logic [15:0] cnt_one;
  logic [15:0] cnt_drop;

  int checks   = 0;
  int failures = 0;

  our_packet_dispatch_if pkt();

  our_packet_dispatch dut (
    .clock     (clock),
    .aclr      (aclr),
    .pkt       (pkt),
    .src_mac   (src_mac),
    .short_err (short_err),
    .cnt_one   (cnt_one),
    .cnt_drop  (cnt_drop)
  );

  always #5 clock = ~clock;

  int one_cyc, two_cyc, short_cnt, rises, low_run, min_gap;
  int both_cnt = 0;
  logic prev_one = 1'b0;

  always @(negedge clock) begin
    if (pkt.ena_one) one_cyc++;
    if (pkt.ena_two) two_cyc++;
    if (short_err) short_cnt++;
    if (pkt.ena_one && pkt.ena_two) both_cnt++;
    if (pkt.ena_one && !prev_one) begin
      rises++;
      if ((rises > 1) && (low_run < min_gap)) min_gap = low_run;
    end
    low_run  = pkt.ena_one ? 0 : low_run + 1;
    prev_one = pkt.ena_one;
  end

  task automatic mon_clear();
    one_cyc = 0; two_cyc = 0; short_cnt = 0; rises = 0; low_run = 0; min_gap = 1000000;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic dv, input logic [7:0] d);
    pkt.rx_dv   = dv;
    pkt.rx_data = d;
    tick();
  endtask

  task automatic do_reset();
    pkt.rx_dv = 1'b0; pkt.rx_data = 8'h00;
    aclr = 1'b1;
    tick(); tick();
    aclr = 1'b0;
    tick(); tick();
  endtask

  task automatic send_hdr(input logic [47:0] dst, input logic [15:0] et,
                          input logic [7:0] typ, input logic [47:0] src, input int nbytes);
    logic [7:0] hdr [16];
    for (int i = 0; i < 6; i++) begin
      hdr[i]   = dst[47-8*i -: 8];
      hdr[6+i] = src[47-8*i -: 8];
    end
    hdr[12] = et[15:8]; hdr[13] = et[7:0]; hdr[14] = typ; hdr[15] = 8'h5A;
    for (int i = 0; i < nbytes; i++) drive(1'b1, hdr[i]);
  endtask

  // data_err counts payload bytes that did not appear on data_out one cycle later,
  // plus a data_out that failed to hold after the frame.
  task automatic send_frame(input logic [47:0] dst, input logic [15:0] et, input logic [7:0] typ,
                            input logic [47:0] src, input int len, input int off,
                            input bit exp_pass, input int idle, output int data_err);
    logic [7:0] d;
    logic [7:0] last;
    data_err = 0;
    last = 8'h00;
    send_hdr(dst, et, typ, src, 16);
    for (int i = 0; i < len; i++) begin
      d = 8'((i + off) & 255);
      drive(1'b1, d);
      if (exp_pass) begin
        if ((pkt.data_out !== d) || !(pkt.ena_one || pkt.ena_two)) data_err++;
        last = d;
      end
    end
    for (int i = 0; i < idle; i++) drive(1'b0, 8'hEE);
    if (exp_pass && (len > 0) && (pkt.data_out !== last)) data_err++;
  endtask

  typedef struct {
    logic [47:0] dst;
    logic [15:0] et;
    logic [7:0]  typ;
    logic [47:0] src;
    int          len;
    int          e_one;
    int          e_two;
    int          e_short;
    logic [15:0] e_c1;
    logic [15:0] e_cd;
    logic [47:0] e_src;
  } vec_t;

  vec_t vecs [11];

  initial begin
    int derr;
    pkt.rx_dv = 1'b0; pkt.rx_data = 8'h00;
    mon_clear();

    vecs[0]  = '{LMAC, 16'h88B5, 8'h01, SA, 524, 524,   0, 0, 16'd1, 16'd0, SA};
    vecs[1]  = '{BMAC, 16'h88B5, 8'h02, SB, 100,   0, 100, 0, 16'd1, 16'd0, SB};
    vecs[2]  = '{WMAC, 16'h88B5, 8'h01, SC,  50,   0,   0, 0, 16'd1, 16'd1, SB};
    vecs[3]  = '{LMAC, 16'h0800, 8'h01, SC,  50,   0,   0, 0, 16'd1, 16'd2, SB};
    vecs[4]  = '{LMAC, 16'h88B5, 8'h07, SC,  50,   0,   0, 0, 16'd1, 16'd3, SB};
    vecs[5]  = '{LMAC, 16'h88B5, 8'h01, SC, 300, 300,   0, 1, 16'd2, 16'd3, SC};
    vecs[6]  = '{LMAC, 16'h88B5, 8'h01, SA, 523, 523,   0, 1, 16'd3, 16'd3, SA};
    vecs[7]  = '{BMAC, 16'h88B5, 8'h01, SB, 525, 525,   0, 0, 16'd4, 16'd3, SB};
    vecs[8]  = '{LMAC, 16'h88B5, 8'h02, SC,  10,   0,  10, 0, 16'd4, 16'd3, SC};
    vecs[9]  = '{LMAC, 16'h88B5, 8'h01, SA,   0,   0,   0, 1, 16'd5, 16'd3, SA};
    vecs[10] = '{BMAC, 16'h88B5, 8'h00, SC,  20,   0,   0, 0, 16'd5, 16'd4, SA};

    // Reset state, sampled while aclr is still asserted.
    tick(); tick();
    check("rst_data_out", 64'(pkt.data_out), 64'h0);
    check("rst_ena_one",  64'(pkt.ena_one),  64'h0);
    check("rst_ena_two",  64'(pkt.ena_two),  64'h0);
    check("rst_src_mac",  64'(src_mac),      64'h0);
    check("rst_short",    64'(short_err),    64'h0);
    check("rst_cnt_one",  64'(cnt_one),      64'h0);
    check("rst_cnt_drop", 64'(cnt_drop),     64'h0);
    aclr = 1'b0;
    tick(); tick();

    for (int k = 0; k < 11; k++) begin
      mon_clear();
      send_frame(vecs[k].dst, vecs[k].et, vecs[k].typ, vecs[k].src, vecs[k].len, k * 7,
                 (vecs[k].e_one + vecs[k].e_two) > 0, 3, derr);
      check($sformatf("v%0d_ena_one_cycles", k), 64'(one_cyc),   64'(vecs[k].e_one));
      check($sformatf("v%0d_ena_two_cycles", k), 64'(two_cyc),   64'(vecs[k].e_two));
      check($sformatf("v%0d_short_pulses", k),   64'(short_cnt), 64'(vecs[k].e_short));
      check($sformatf("v%0d_cnt_one", k),        64'(cnt_one),   64'(vecs[k].e_c1));
      check($sformatf("v%0d_cnt_drop", k),       64'(cnt_drop),  64'(vecs[k].e_cd));
      check($sformatf("v%0d_src_mac", k),        64'(src_mac),   64'(vecs[k].e_src));
      check($sformatf("v%0d_data_errs", k),      64'(derr),      64'h0);
    end

    // Header abort: rx_dv drops where byte 9 would be.
    mon_clear();
    send_hdr(LMAC, 16'h88B5, 8'h01, SB, 9);
    drive(1'b0, 8'h00); drive(1'b0, 8'h00);
    check("abort_cnt_drop", 64'(cnt_drop), 64'd5);
    check("abort_cnt_one",  64'(cnt_one),  64'd5);
    check("abort_ena",      64'(one_cyc + two_cyc), 64'd0);
    check("abort_src_mac",  64'(src_mac),  64'(SA));

    // Back-to-back ONE frames separated by a single idle cycle.
    do_reset();
    mon_clear();
    send_frame(LMAC, 16'h88B5, 8'h01, SB, 524, 0, 1'b1, 1, derr);
    check("b2b_f1_data_errs", 64'(derr), 64'h0);
    send_frame(LMAC, 16'h88B5, 8'h01, SC, 524, 3, 1'b1, 3, derr);
    check("b2b_f2_data_errs", 64'(derr), 64'h0);
    check("b2b_cnt_one",      64'(cnt_one), 64'd2);
    check("b2b_rises",        64'(rises), 64'd2);
    check("b2b_gap_ge1",      64'(min_gap >= 1), 64'd1);
    check("b2b_cycles",       64'(one_cyc), 64'd1048);
    check("b2b_short",        64'(short_cnt), 64'd0);
    check("b2b_src_mac",      64'(src_mac), 64'(SC));

    // Asynchronous reset after payload byte 199, remainder of the frame ignored.
    do_reset();
    send_hdr(LMAC, 16'h88B5, 8'h01, SA, 16);
    for (int i = 0; i < 200; i++) drive(1'b1, 8'(i));
    check("aclr_pre_ena_one", 64'(pkt.ena_one), 64'd1);
    aclr = 1'b1;
    #1;
    check("aclr_ena_one_now", 64'(pkt.ena_one), 64'd0);
    check("aclr_cnt_one_now", 64'(cnt_one),     64'd0);
    mon_clear();
    drive(1'b1, 8'd200);
    aclr = 1'b0;
    for (int i = 201; i < 524; i++) drive(1'b1, 8'(i));
    drive(1'b0, 8'h00); drive(1'b0, 8'h00);
    check("aclr_rest_ignored", 64'(one_cyc + two_cyc), 64'd0);
    check("aclr_rest_no_drop", 64'(cnt_drop), 64'd0);
    check("aclr_rest_no_one",  64'(cnt_one),  64'd0);
    mon_clear();
    send_frame(LMAC, 16'h88B5, 8'h01, SB, 524, 0, 1'b1, 3, derr);
    check("aclr_next_cycles",    64'(one_cyc), 64'd524);
    check("aclr_next_data_errs", 64'(derr),    64'h0);
    check("aclr_next_cnt_one",   64'(cnt_one), 64'd1);
    check("aclr_next_src_mac",   64'(src_mac), 64'(SB));

    // Saturation: preload both counters just below the ceiling.
    do_reset();
    force dut.u_cnt_one.count_q  = 16'hFFFE;
    force dut.u_cnt_drop.count_q = 16'hFFFE;
    #2;
    release dut.u_cnt_one.count_q;
    release dut.u_cnt_drop.count_q;
    tick();
    check("sat_preload_one", 64'(cnt_one), 64'hFFFE);
    for (int f = 0; f < 3; f++) begin
      send_frame(LMAC, 16'h88B5, 8'h01, SA, 4, 0, 1'b1, 2, derr);
      send_frame(WMAC, 16'h88B5, 8'h01, SA, 4, 0, 1'b0, 2, derr);
      if (f == 0) begin
        check("sat_one_first",  64'(cnt_one),  64'hFFFF);
        check("sat_drop_first", 64'(cnt_drop), 64'hFFFF);
      end
    end
    check("sat_cnt_one",  64'(cnt_one),  64'hFFFF);
    check("sat_cnt_drop", 64'(cnt_drop), 64'hFFFF);

    check("ena_never_both", 64'(both_cnt), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/our_packet_dispatch.md
OUR_PACKET_DISPATCH -- requirements
Module: our_packet_dispatch

Interface
REQ-001 Parameters SHALL be: LOCAL_MAC, 48'h02_00_00_00_00_01, station address; ETHERTYPE, 16'h88B5, accepted EtherType; TYPE_ONE, 8'h01, type code for ONE packets; TYPE_TWO, 8'h02, type code for TWO packets; ONE_LEN, 524, minimum payload bytes of a ONE packet.
REQ-002 Ports SHALL be: clock  in  1  single system clock, rising edge.
REQ-003 aclr  in  1  reset, asynchronous, active-high.
REQ-004 rx_data  in  8  received byte, preamble/SFD already stripped, FCS checked upstream.
REQ-005 rx_dv  in  1  frame valid; contiguous high from the first destination-MAC byte to the last payload byte.
REQ-006 data_out  out  8  registered payload byte, shared by both type outputs.
REQ-007 ena_one  out  1  data_out is a byte of a ONE payload; drives the ONE parser's ena.
REQ-008 ena_two  out  1  data_out is a byte of a TWO payload.
REQ-009 src_mac  out  48  source MAC of the last accepted frame.
REQ-010 short_err  out  1  one-cycle pulse: ONE frame ended with fewer than ONE_LEN payload bytes.
REQ-011 cnt_one, cnt_drop  out  16 each  accepted-ONE and dropped-frame counters, saturating at 16'hFFFF.

Function
REQ-012 Frame layout SHALL be: bytes 0-5 destination MAC; 6-11 source MAC; 12-13 EtherType, MSB first; 14 type code; 15 reserved and ignored; 16 onward payload.
REQ-013 The FSM SHALL have the states IDLE, HDR, PASS_ONE, PASS_TWO and DROP.
REQ-014 IDLE -> HDR SHALL occur on rx_dv=1; byte index 0 is captured in that same cycle.
REQ-015 HDR SHALL count bytes 0-15 with a 5-bit index and compare them on the fly.
REQ-016 A destination MAC SHALL match when it equals LOCAL_MAC or 48'hFFFF_FFFF_FFFF.
REQ-017 On byte 15, a frame with destination match, EtherType match and type TYPE_ONE SHALL go to PASS_ONE.
REQ-018 On byte 15, a frame with destination match, EtherType match and type TYPE_TWO SHALL go to PASS_TWO.
REQ-019 On byte 15, every other frame SHALL go to DROP.
REQ-020 PASS_x and DROP SHALL return to IDLE on the first cycle with rx_dv=0.
REQ-021 rx_dv falling while in HDR SHALL return the FSM to IDLE and count the frame as dropped.
REQ-022 Payload latency SHALL be one cycle: data_out <= rx_data and ena_x <= 1 for every rx_dv=1 cycle in PASS_x.
REQ-023 ena_x SHALL fall on the cycle after rx_dv falls.
REQ-024 ena_one and ena_two SHALL never be high together.
REQ-025 ena_x SHALL stay low for at least one cycle between consecutive frames, including back-to-back frames with a single idle cycle.
REQ-026 data_out SHALL hold its last value while both ena outputs are low.
REQ-027 A 10-bit payload counter SHALL count PASS_ONE bytes, saturating at 1023.
REQ-028 If rx_dv falls with payload count < ONE_LEN, short_err SHALL pulse on the cycle ena_one falls.
REQ-029 A ONE frame longer than ONE_LEN SHALL be forwarded in full; the trailing bytes are the downstream parser's concern.
REQ-030 src_mac SHALL update only on a transition into PASS_ONE or PASS_TWO.
REQ-031 cnt_one SHALL increment on entry to PASS_ONE.
REQ-032 cnt_drop SHALL increment on entry to DROP or on a HDR abort.
REQ-033 Both counters SHALL hold at 16'hFFFF.
REQ-034 A TWO frame SHALL never pulse short_err.

Reset
REQ-035 aclr SHALL asynchronously force: state IDLE, data_out 0, ena_one 0, ena_two 0, src_mac 0, short_err 0, cnt_one 0, cnt_drop 0, and all internal indices and counters 0.
REQ-036 aclr asserted mid-frame SHALL drop ena_x immediately.
REQ-037 After reset release during a frame, the block SHALL ignore that frame's remainder until rx_dv is seen low for at least one cycle.
REQ-038 Reset release SHALL be synchronised externally; this block SHALL not resynchronise aclr.

Structure
REQ-039 A shared package SHALL hold the ETHERTYPE, TYPE_ONE, TYPE_TWO and broadcast MAC constants, ONE_LEN, and the state encoding, for reuse by the TWO parser and the TX framer.
REQ-040 One sub-module SHALL be natural: our_sat_counter (16-bit saturating counter with inc and aclr), instantiated twice.
REQ-041 The FSM and the header comparators SHALL stay in the top module.

Verification
REQ-042 Frame to LOCAL_MAC, EtherType 88B5, type 01, 524 payload bytes 00..FF repeating -> ena_one high for exactly 524 cycles, data_out matches input delayed by 1 cycle, cnt_one=1, short_err never pulses.
REQ-043 Broadcast destination, type 02, 100 payload bytes -> ena_two high for 100 cycles, ena_one stays 0, src_mac updated.
REQ-044 Wrong destination 02:00:00:00:00:09, then EtherType 0800, then type 07 -> no ena_x, cnt_drop=3, src_mac unchanged.
REQ-045 ONE frame truncated after 300 payload bytes -> ena_one high for 300 cycles, then one short_err pulse; rx_dv dropped at byte 9 -> IDLE, cnt_drop+1.
REQ-046 Two ONE frames with a single idle cycle between them -> ena_one low for at least one cycle between frames, cnt_one=2.
REQ-047 aclr pulsed at payload byte 200 -> ena_one drops immediately, rest of that frame ignored, next frame accepted normally; counters preloaded to FFFE and fed 3 frames -> counters hold FFFF.
